// File: rtl/alu_seq_acc.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes, registered result/flags,
// an iterative shift-add multiplier and an accumulator that can replace operand A.
module alu_seq_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic             r_z, r_c, r_v, r_n;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH:0]   w_wide;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;
  logic [PW-1:0]    w_prod_nxt;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_last;
  logic             w_accept;

  // Single-cycle datapath for every opcode except MUL
  always_comb begin
    w_opa  = acc_sel ? (acc_clr ? '0 : r_acc) : a;
    w_wide = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (op)
      OP_ADD: begin
        w_wide = {1'b0, w_opa} + {1'b0, b};
        w_c    = w_wide[WIDTH];
        w_v    = (w_opa[MSB] == b[MSB]) && (w_wide[MSB] != w_opa[MSB]);
      end
      OP_SUB: begin
        w_wide = {1'b0, w_opa} - {1'b0, b};
        w_c    = w_wide[WIDTH];
        w_v    = (w_opa[MSB] != b[MSB]) && (w_wide[MSB] != w_opa[MSB]);
      end
      OP_AND: w_wide = {1'b0, w_opa & b};
      OP_OR:  w_wide = {1'b0, w_opa | b};
      OP_XOR: w_wide = {1'b0, w_opa ^ b};
      OP_SHL: begin
        w_wide = {1'b0, w_opa[WIDTH-2:0], 1'b0};
        w_c    = w_opa[MSB];
      end
      OP_SHR: begin
        w_wide = {2'b00, w_opa[WIDTH-1:1]};
        w_c    = w_opa[0];
      end
      default: w_wide = '0;
    endcase
    w_res = w_wide[WIDTH-1:0];
  end

  // One shift-add step; the counter always runs WIDTH steps regardless of operands
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res  = w_prod_nxt[WIDTH-1:0];
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept   = in_valid && r_in_ready && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_acc       <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_n         <= 1'b0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (acc_clr) r_acc <= '0;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (op == OP_MUL) begin
              r_mcand  <= PW'(w_opa);
              r_mplier <= b;
              r_prod   <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_EXEC;
            end else begin
              r_result    <= w_res;
              r_z         <= (w_res == '0);
              r_c         <= w_c;
              r_v         <= w_v;
              r_n         <= w_res[MSB];
              r_acc       <= w_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result    <= w_mul_res;
            r_z         <= (w_mul_res == '0);
            r_c         <= |w_prod_nxt[PW-1:WIDTH];
            r_v         <= 1'b0;
            r_n         <= w_mul_res[MSB];
            r_acc       <= w_mul_res;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_n    = r_n;

endmodule
